// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard receiver and make/break decoder:
// receiver state encoding, scan-code prefixes and the game's direction keys.
package ps2_pkg;

  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
    RX_DATA = 2'd1,
    RX_STOP = 2'd2
  } rx_state_e;

  localparam int unsigned DATA_BITS = 8;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  // Set-2 make codes used by the game; arrows arrive behind an E0 prefix.
  localparam logic [7:0] KEY_W     = 8'h1D;
  localparam logic [7:0] KEY_A     = 8'h1C;
  localparam logic [7:0] KEY_S     = 8'h1B;
  localparam logic [7:0] KEY_D     = 8'h23;
  localparam logic [7:0] KEY_UP    = 8'h75;
  localparam logic [7:0] KEY_LEFT  = 8'h6B;
  localparam logic [7:0] KEY_DOWN  = 8'h72;
  localparam logic [7:0] KEY_RIGHT = 8'h74;

  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: synchronises the keyboard pins, samples on PS2_CLK
// falling edges and delivers one checked byte per 11-bit frame.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 5000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       byte_error
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] PARITY_IDX = 4'(DATA_BITS);

  logic clk_meta_q, clk_sync_q, clk_prev_q;
  logic dat_meta_q, dat_sync_q;

  rx_state_e state_q, state_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

  logic fall;
  logic tmo_hit;

  // Pins idle high, so the synchronisers reset to 1 to avoid a phantom edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
    end else begin
      clk_meta_q <= ps2_clk;
      clk_sync_q <= clk_meta_q;
      clk_prev_q <= clk_sync_q;
      dat_meta_q <= ps2_dat;
      dat_sync_q <= dat_meta_q;
    end
  end

  assign fall    = clk_prev_q & ~clk_sync_q;
  assign tmo_hit = (tmo_cnt_q == TMO_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= RX_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      tmo_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    byte_valid = 1'b0;
    byte_error = 1'b0;

    // Counts cycles since the last sampled edge of the current frame.
    if (state_q == RX_IDLE || fall) begin
      tmo_cnt_d = '0;
    end else begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end

    case (state_q)
      RX_IDLE: begin
        if (fall && !dat_sync_q) begin
          state_d   = RX_DATA;
          bit_cnt_d = '0;
        end
      end

      RX_DATA: begin
        if (fall) begin
          if (bit_cnt_q == PARITY_IDX) begin
            parity_d = dat_sync_q;
            state_d  = RX_STOP;
          end else begin
            shift_d   = {dat_sync_q, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end else if (tmo_hit) begin
          byte_error = 1'b1;
          state_d    = RX_IDLE;
        end
      end

      RX_STOP: begin
        if (fall) begin
          state_d = RX_IDLE;
          if (dat_sync_q && odd_parity_ok(shift_q, parity_q)) begin
            byte_valid = 1'b1;
          end else begin
            byte_error = 1'b1;
          end
        end else if (tmo_hit) begin
          byte_error = 1'b1;
          state_d    = RX_IDLE;
        end
      end

      default: begin
        state_d = RX_IDLE;
      end
    endcase
  end

  assign byte_data = shift_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard front end for the game: receives scan-code bytes and folds
// E0/F0 prefixes into make (key_valid) and break (key_release) events.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 5000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [7:0] last_key_received,
  output logic       key_valid,
  output logic       key_extended,
  output logic       key_release,
  output logic       frame_error
);

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_error;

  logic       ext_pending_q, ext_pending_d;
  logic       brk_pending_q, brk_pending_d;
  logic [7:0] last_key_q, last_key_d;
  logic       key_ext_q, key_ext_d;
  logic       key_valid_q, key_valid_d;
  logic       key_release_q, key_release_d;
  logic       frame_error_q, frame_error_d;

  ps2_rx_frame #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clock     (clock),
    .reset     (reset),
    .ps2_clk   (PS2_CLK),
    .ps2_dat   (PS2_DAT),
    .byte_data (rx_byte),
    .byte_valid(rx_valid),
    .byte_error(rx_error)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      ext_pending_q <= 1'b0;
      brk_pending_q <= 1'b0;
      last_key_q    <= 8'h00;
      key_ext_q     <= 1'b0;
      key_valid_q   <= 1'b0;
      key_release_q <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      ext_pending_q <= ext_pending_d;
      brk_pending_q <= brk_pending_d;
      last_key_q    <= last_key_d;
      key_ext_q     <= key_ext_d;
      key_valid_q   <= key_valid_d;
      key_release_q <= key_release_d;
      frame_error_q <= frame_error_d;
    end
  end

  // A bad frame only raises frame_error; prefixes seen so far stay armed.
  always_comb begin
    ext_pending_d = ext_pending_q;
    brk_pending_d = brk_pending_q;
    last_key_d    = last_key_q;
    key_ext_d     = key_ext_q;
    key_valid_d   = 1'b0;
    key_release_d = 1'b0;
    frame_error_d = rx_error;

    if (rx_valid) begin
      if (rx_byte == PS2_EXT) begin
        ext_pending_d = 1'b1;
      end else if (rx_byte == PS2_BRK) begin
        brk_pending_d = 1'b1;
      end else begin
        if (brk_pending_q) begin
          key_release_d = 1'b1;
        end else begin
          last_key_d  = rx_byte;
          key_ext_d   = ext_pending_q;
          key_valid_d = 1'b1;
        end
        ext_pending_d = 1'b0;
        brk_pending_d = 1'b0;
      end
    end
  end

  assign last_key_received = last_key_q;
  assign key_extended      = key_ext_q;
  assign key_valid         = key_valid_q;
  assign key_release       = key_release_q;
  assign frame_error       = frame_error_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: a table of single frames with expected
// pulse counts and outputs, plus sequences for latency, timeout and reset.
module tb_ps2_key_decoder;

  localparam int TMO = 100;

  logic       clock;
  logic       reset;
  logic       PS2_CLK;
  logic       PS2_DAT;
  logic [7:0] last_key_received;
  logic       key_valid;
  logic       key_extended;
  logic       key_release;
  logic       frame_error;

  int checks = 0;
  int errors = 0;

  int n_valid   = 0;
  int n_rel     = 0;
  int n_err     = 0;
  int n_overlap = 0;

  typedef struct {
    logic [7:0] code;
    logic       flip_par;
    logic       stop_bit;
    int         exp_valid;
    int         exp_rel;
    int         exp_err;
    logic [7:0] exp_key;
    logic       exp_ext;
  } vec_t;

  vec_t vq[$];

  ps2_key_decoder #(
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .PS2_CLK          (PS2_CLK),
    .PS2_DAT          (PS2_DAT),
    .last_key_received(last_key_received),
    .key_valid        (key_valid),
    .key_extended     (key_extended),
    .key_release      (key_release),
    .frame_error      (frame_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (key_valid) n_valid++;
    if (key_release) n_rel++;
    if (frame_error) n_err++;
    if ((int'(key_valid) + int'(key_release) + int'(frame_error)) > 1) n_overlap++;
  end

  initial begin
    #(500_000);
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, got, want);
    end
  endtask

  task automatic ps2_bit(input logic b);
    @(negedge clock);
    PS2_DAT = b;
    repeat (4) @(negedge clock);
    PS2_CLK = 1'b0;
    repeat (8) @(negedge clock);
    PS2_CLK = 1'b1;
    repeat (4) @(negedge clock);
  endtask

  // First nbits of a frame: start, data LSB first, odd parity.
  task automatic send_partial(input logic [7:0] code, input int nbits);
    logic [10:0] bits;
    bits = {1'b1, ~^code, code, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(bits[i]);
  endtask

  task automatic send_frame(input logic [7:0] code, input logic flip, input logic stop);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(code[i]);
    ps2_bit((~^code) ^ flip);
    ps2_bit(stop);
  endtask

  task automatic add(input logic [7:0] c, input logic fp, input logic sb, input int v,
                     input int r, input int e, input logic [7:0] k, input logic x);
    vec_t t;
    t.code = c; t.flip_par = fp; t.stop_bit = sb;
    t.exp_valid = v; t.exp_rel = r; t.exp_err = e; t.exp_key = k; t.exp_ext = x;
    vq.push_back(t);
  endtask

  initial begin
    int v0, r0, e0, lat;
    bit found;

    //   code   flip  stop  valid rel err key    ext
    add(8'h1D, 1'b0, 1'b1, 1, 0, 0, 8'h1D, 1'b0);
    add(8'hE0, 1'b0, 1'b1, 0, 0, 0, 8'h1D, 1'b0);
    add(8'h75, 1'b0, 1'b1, 1, 0, 0, 8'h75, 1'b1);
    add(8'h1D, 1'b0, 1'b1, 1, 0, 0, 8'h1D, 1'b0);
    add(8'h1D, 1'b0, 1'b1, 1, 0, 0, 8'h1D, 1'b0);
    add(8'hF0, 1'b0, 1'b1, 0, 0, 0, 8'h1D, 1'b0);
    add(8'h1D, 1'b0, 1'b1, 0, 1, 0, 8'h1D, 1'b0);
    add(8'hE0, 1'b0, 1'b1, 0, 0, 0, 8'h1D, 1'b0);
    add(8'hF0, 1'b0, 1'b1, 0, 0, 0, 8'h1D, 1'b0);
    add(8'h75, 1'b0, 1'b1, 0, 1, 0, 8'h1D, 1'b0);
    add(8'hF0, 1'b0, 1'b1, 0, 0, 0, 8'h1D, 1'b0);
    add(8'hE0, 1'b0, 1'b1, 0, 0, 0, 8'h1D, 1'b0);
    add(8'h6B, 1'b0, 1'b1, 0, 1, 0, 8'h1D, 1'b0);
    add(8'hE0, 1'b0, 1'b1, 0, 0, 0, 8'h1D, 1'b0);
    add(8'h6B, 1'b0, 1'b1, 1, 0, 0, 8'h6B, 1'b1);
    add(8'h23, 1'b1, 1'b1, 0, 0, 1, 8'h6B, 1'b1);
    add(8'h23, 1'b0, 1'b0, 0, 0, 1, 8'h6B, 1'b1);
    add(8'hE0, 1'b0, 1'b1, 0, 0, 0, 8'h6B, 1'b1);
    add(8'h74, 1'b1, 1'b1, 0, 0, 1, 8'h6B, 1'b1);
    add(8'h74, 1'b0, 1'b1, 1, 0, 0, 8'h74, 1'b1);
    add(8'h23, 1'b0, 1'b1, 1, 0, 0, 8'h23, 1'b0);

    PS2_CLK = 1'b1;
    PS2_DAT = 1'b1;
    reset   = 1'b1;
    repeat (3) @(negedge clock);
    check("reset_key", int'(last_key_received), 8'h00);
    check("reset_valid", int'(key_valid), 0);
    check("reset_ext", int'(key_extended), 0);
    check("reset_release", int'(key_release), 0);
    check("reset_error", int'(frame_error), 0);
    reset = 1'b0;
    repeat (3) @(negedge clock);

    foreach (vq[i]) begin
      v0 = n_valid; r0 = n_rel; e0 = n_err;
      send_frame(vq[i].code, vq[i].flip_par, vq[i].stop_bit);
      repeat (6) @(negedge clock);
      $display("frame %0d code %02h: valid %0d rel %0d err %0d key %02h ext %0d", i,
               vq[i].code, n_valid - v0, n_rel - r0, n_err - e0, last_key_received,
               key_extended);
      check($sformatf("vec%0d_valid", i), n_valid - v0, vq[i].exp_valid);
      check($sformatf("vec%0d_release", i), n_rel - r0, vq[i].exp_rel);
      check($sformatf("vec%0d_error", i), n_err - e0, vq[i].exp_err);
      check($sformatf("vec%0d_key", i), int'(last_key_received), int'(vq[i].exp_key));
      check($sformatf("vec%0d_ext", i), int'(key_extended), int'(vq[i].exp_ext));
    end

    // Latency from the stop-bit pin edge to key_valid.
    v0 = n_valid;
    send_partial(8'h1C, 10);
    @(negedge clock);
    PS2_DAT = 1'b1;
    repeat (4) @(negedge clock);
    PS2_CLK = 1'b0;
    lat = 0;
    found = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      if (key_valid && !found) begin
        lat = k;
        found = 1'b1;
      end
    end
    PS2_CLK = 1'b1;
    repeat (6) @(negedge clock);
    $display("latency frame 1C: %0d cycles key %02h", lat, last_key_received);
    check("latency_cycles", lat, 3);
    check("latency_valid_count", n_valid - v0, 1);
    check("latency_key", int'(last_key_received), 8'h1C);

    // Frame abandoned after start + 4 data bits must time out once.
    v0 = n_valid; e0 = n_err;
    send_partial(8'h55, 5);
    repeat (TMO + 20) @(negedge clock);
    $display("timeout partial frame: err %0d valid %0d", n_err - e0, n_valid - v0);
    check("timeout_error", n_err - e0, 1);
    check("timeout_valid", n_valid - v0, 0);
    check("timeout_key", int'(last_key_received), 8'h1C);
    send_frame(8'h1B, 1'b0, 1'b1);
    repeat (6) @(negedge clock);
    $display("after timeout frame 1B: valid %0d err %0d key %02h", n_valid - v0, n_err - e0,
             last_key_received);
    check("post_timeout_valid", n_valid - v0, 1);
    check("post_timeout_error", n_err - e0, 1);
    check("post_timeout_key", int'(last_key_received), 8'h1B);

    // Reset after the fifth data bit abandons the frame silently.
    v0 = n_valid; e0 = n_err;
    send_partial(8'hA5, 6);
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check("midreset_key", int'(last_key_received), 8'h00);
    reset = 1'b0;
    repeat (TMO + 20) @(negedge clock);
    send_frame(8'h1C, 1'b0, 1'b1);
    repeat (6) @(negedge clock);
    $display("after mid-frame reset frame 1C: valid %0d err %0d key %02h", n_valid - v0,
             n_err - e0, last_key_received);
    check("midreset_error", n_err - e0, 0);
    check("midreset_valid", n_valid - v0, 1);
    check("midreset_newkey", int'(last_key_received), 8'h1C);
    check("midreset_ext", int'(key_extended), 0);

    check("pulse_overlap", n_overlap, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
